// File: rtl/dmem_responder.sv
// dmem_responder: single-word load/store responder for the core data port
//
// Services one request at a time from an internal word-addressed array and
// returns one response per request. Misaligned or out-of-range accesses are
// answered with rsp_err=1 and never touch the array.
//
// Parameters:
//   DEPTH    words in the array (power of two)
//   LATENCY  cycles from load acceptance to rsp_valid (1..15)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle (high only when idle)
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index is req_addr[31:2]
//   req_wdata  store data
//   req_be     byte-lane write enables (only with DMEM_BYTE_WRITE_EN)
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  consumer accepts response
//   rsp_rdata  load data, 0 for stores and errors
//   rsp_err    access was misaligned or out of range
//
// Build option: define DMEM_BYTE_WRITE_EN to add req_be and per-lane stores.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [AW-1:0] idx_q;
  logic err_q;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic bad;
  logic accept;
  assign idx = req_addr[AW+1:2];
  assign bad = (|req_addr[1:0]) || (req_addr[31:2] >= 30'(DEPTH));
  assign accept = (state == IDLE) && req_valid;
  // Stores land on the acceptance edge; the rst term keeps a request
  // presented while reset is asserted from writing.
  always_ff @(posedge clk)
    if (rst && accept && req_we && !bad)
`ifdef DMEM_BYTE_WRITE_EN
      for (int k = 0; k < 4; k++)
        if (req_be[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
`else
      mem[idx] <= req_wdata;
`endif
  // Response data is captured on entry to RESP; rsp_valid follows one edge
  // later, so a store answers after one edge and a load after LATENCY edges.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else
      case (state)
        IDLE:
          if (req_valid) begin
            req_ready <= 1'b0;
            idx_q     <= idx;
            err_q     <= bad;
            cnt       <= '0;
            if (req_we || LATENCY == 1) begin
              state     <= RESP;
              rsp_err   <= bad;
              rsp_rdata <= (req_we || bad) ? 32'd0 : mem[idx];
            end else
              state <= WAIT;
          end
        WAIT:
          if (cnt == 4'(LATENCY - 2)) begin
            state     <= RESP;
            rsp_err   <= err_q;
            rsp_rdata <= err_q ? 32'd0 : mem[idx_q];
          end else
            cnt <= cnt + 4'd1;
        RESP:
          if (!rsp_valid)
            rsp_valid <= 1'b1;
          else if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] er;
    logic        ee;
    string       nm;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0] req_be = 4'hF;
`endif
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  int total = 0;
  int bad = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ee, input string nm);
    int n;
    check({nm, " ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    check({nm, " ready_busy"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, " latency"}, 32'(n), we ? 32'd1 : 32'(LAT));
    check({nm, " rdata"}, rsp_rdata, er);
    check({nm, " err"}, 32'(rsp_err), 32'(ee));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({nm, " valid_after"}, 32'(rsp_valid), 32'd0);
    check({nm, " ready_after"}, 32'(req_ready), 32'd1);
  endtask
  initial begin
    int n;
    v.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "st_10"});
    v.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "ld_10"});
    v.push_back('{1'b1, 32'h12,       32'h12345678, 4'hF, 32'h0,        1'b1, "st_mis"});
    v.push_back('{1'b0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 1'b0, "ld_10_kept"});
    v.push_back('{1'b0, 32'h1000,     32'h0,        4'hF, 32'h0,        1'b1, "ld_oor"});
    v.push_back('{1'b1, 32'h1000,     32'h55555555, 4'hF, 32'h0,        1'b1, "st_oor"});
    v.push_back('{1'b1, 32'hFFC,      32'h0BADF00D, 4'hF, 32'h0,        1'b0, "st_last"});
    v.push_back('{1'b0, 32'hFFC,      32'h0,        4'hF, 32'h0BADF00D, 1'b0, "ld_last"});
    v.push_back('{1'b0, 32'h11,       32'h0,        4'hF, 32'h0,        1'b1, "ld_mis"});
    v.push_back('{1'b1, 32'h0,        32'h11223344, 4'hF, 32'h0,        1'b0, "st_0"});
    v.push_back('{1'b0, 32'h0,        32'h0,        4'hF, 32'h11223344, 1'b0, "ld_0"});
    v.push_back('{1'b0, 32'h80000000, 32'h0,        4'hF, 32'h0,        1'b1, "ld_hi"});
    v.push_back('{1'b0, 32'h0,        32'h0,        4'hF, 32'h11223344, 1'b0, "ld_0_kept"});
`ifdef DMEM_BYTE_WRITE_EN
    v.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0,        1'b0, "be_init"});
    v.push_back('{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "be_0101"});
    v.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, "be_ld"});
    v.push_back('{1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, "be_none"});
    v.push_back('{1'b0, 32'h20, 32'h0,        4'hF, 32'h11BB33DD, 1'b0, "be_ld2"});
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst valid", 32'(rsp_valid), 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst err", 32'(rsp_err), 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst ready", 32'(req_ready), 32'd1);
    check("post_rst valid", 32'(rsp_valid), 32'd0);
    foreach (v[i]) begin
`ifdef DMEM_BYTE_WRITE_EN
      req_be = v[i].be;
`endif
      xfer(v[i].we, v[i].addr, v[i].wdata, v[i].er, v[i].ee, v[i].nm);
    end
`ifdef DMEM_BYTE_WRITE_EN
    req_be = 4'hF;
`endif
    // backpressure: stalled load, with an ignored store offered meanwhile
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'hFFC;
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp latency", 32'(n), 32'(LAT));
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp valid", 32'(rsp_valid), 32'd1);
      check("bp rdata", rsp_rdata, 32'h0BADF00D);
      check("bp err", 32'(rsp_err), 32'd0);
      check("bp ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp release ready", 32'(req_ready), 32'd1);
    check("bp release valid", 32'(rsp_valid), 32'd0);
    check("bp release rdata", rsp_rdata, 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_10_no_ignored_store");
    // reset while a load waits for the array
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'hFFC;
    tick();
    req_valid = 1'b0;
    check("rw busy", 32'(req_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rw ready", 32'(req_ready), 32'd1);
    check("rw valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rw no_rsp", 32'(rsp_valid), 32'd0);
      check("rw idle", 32'(req_ready), 32'd1);
    end
    xfer(1'b0, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0, "ld_last_after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
